// File: rtl/interface_controller_out_pkg.sv
// rtl/interface_controller_out_pkg.sv - shared opcodes, field positions and read-side FSM states
package ifc_pkg;
  localparam int HOST_ADDR_WIDTH = 4;
  localparam int HDR_OVERHEAD    = 21;

  localparam logic [2:0] OP_CONNECT    = 3'b000;
  localparam logic [2:0] OP_DISCONNECT = 3'b001;
  localparam logic [2:0] OP_SEND_DATA  = 3'b010;

  localparam int OPC_LSB  = 0;
  localparam int OPC_MSB  = 2;
  localparam int ADDR_LSB = 3;

  typedef logic [2:0] state_t;
  localparam state_t ST_CMD_RD = 3'd0;
  localparam state_t ST_CMD    = 3'd1;
  localparam state_t ST_LEN_RD = 3'd2;
  localparam state_t ST_LEN    = 3'd3;
  localparam state_t ST_PAY_RD = 3'd4;
  localparam state_t ST_PAY    = 3'd5;
  localparam state_t ST_HOLD   = 3'd6;
endpackage

// File: rtl/interface_controller_out_if.sv
// rtl/interface_controller_out_if.sv - FIFO read port, host events and payload stream
interface interface_controller_out_if #(parameter int NUM_HOST = 4);
  logic                empty_i;
  logic [7:0]          data_i;
  logic                readreq_o;
  logic                connect_o;
  logic                disconnect_o;
  logic [NUM_HOST-1:0] host_addr_o;
  logic                msg_start_o;
  logic [7:0]          msg_length_o;
  logic [7:0]          payload_o;
  logic                payload_valid_o;
  logic                payload_last_o;
  logic                payload_ready_i;
  logic                msg_done_o;
  logic                err_o;

  modport master (
    input  empty_i, data_i, payload_ready_i,
    output readreq_o, connect_o, disconnect_o, host_addr_o, msg_start_o, msg_length_o,
           payload_o, payload_valid_o, payload_last_o, msg_done_o, err_o
  );

  modport slave (
    output empty_i, data_i, payload_ready_i,
    input  readreq_o, connect_o, disconnect_o, host_addr_o, msg_start_o, msg_length_o,
           payload_o, payload_valid_o, payload_last_o, msg_done_o, err_o
  );
endinterface

// File: rtl/interface_controller_out.sv
// rtl/interface_controller_out.sv - decodes the interface FIFO byte stream into host events and payload
module interface_controller_out
  import ifc_pkg::*;
#(
  parameter int NUM_HOST     = HOST_ADDR_WIDTH,
  parameter int HDR_OVERHEAD = ifc_pkg::HDR_OVERHEAD
) (
  input logic clk,
  input logic rst,
  interface_controller_out_if.master bus
);
  localparam logic [7:0] HDR8 = 8'(HDR_OVERHEAD);

  state_t              state;
  logic [7:0]          cnt;
  logic                connect_r, disconnect_r, msg_start_r, msg_done_r, err_r;
  logic [NUM_HOST-1:0] host_addr_r;
  logic [7:0]          msg_length_r, payload_r;
  logic                payload_valid_r, payload_last_r;
  logic                rd_state;
  logic [2:0]          opcode;
  logic [7:0]          pay_count;

  assign rd_state  = (state == ST_CMD_RD) || (state == ST_LEN_RD) || (state == ST_PAY_RD);
  // Gated by reset so the pop request is low while held in reset like every other output.
  assign bus.readreq_o = rst && rd_state && !bus.empty_i;
  assign opcode    = bus.data_i[OPC_MSB:OPC_LSB];
  assign pay_count = bus.data_i - HDR8;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_CMD_RD;
      cnt             <= 8'd0;
      connect_r       <= 1'b0;
      disconnect_r    <= 1'b0;
      msg_start_r     <= 1'b0;
      msg_done_r      <= 1'b0;
      err_r           <= 1'b0;
      host_addr_r     <= '0;
      msg_length_r    <= 8'd0;
      payload_r       <= 8'd0;
      payload_valid_r <= 1'b0;
      payload_last_r  <= 1'b0;
    end else begin
      connect_r    <= 1'b0;
      disconnect_r <= 1'b0;
      msg_start_r  <= 1'b0;
      msg_done_r   <= 1'b0;
      err_r        <= 1'b0;
      case (state)
        ST_CMD_RD: if (!bus.empty_i) state <= ST_CMD;
        ST_CMD: begin
          state <= ST_CMD_RD;
          case (opcode)
            OP_CONNECT: begin
              connect_r   <= 1'b1;
              host_addr_r <= bus.data_i[ADDR_LSB +: NUM_HOST];
            end
            OP_DISCONNECT: begin
              disconnect_r <= 1'b1;
              host_addr_r  <= bus.data_i[ADDR_LSB +: NUM_HOST];
            end
            OP_SEND_DATA: begin
              host_addr_r <= bus.data_i[ADDR_LSB +: NUM_HOST];
              state       <= ST_LEN_RD;
            end
            default: err_r <= 1'b1;
          endcase
        end
        ST_LEN_RD: if (!bus.empty_i) state <= ST_LEN;
        ST_LEN: begin
          if (bus.data_i < HDR8) begin
            err_r <= 1'b1;
            state <= ST_CMD_RD;
          end else begin
            msg_start_r  <= 1'b1;
            msg_length_r <= pay_count;
            cnt          <= pay_count;
            if (pay_count == 8'd0) begin
              msg_done_r <= 1'b1;
              state      <= ST_CMD_RD;
            end else begin
              state <= ST_PAY_RD;
            end
          end
        end
        ST_PAY_RD: if (!bus.empty_i) state <= ST_PAY;
        ST_PAY: begin
          payload_r       <= bus.data_i;
          payload_valid_r <= 1'b1;
          payload_last_r  <= (cnt == 8'd1);
          state           <= ST_HOLD;
        end
        ST_HOLD: if (bus.payload_ready_i) begin
          payload_valid_r <= 1'b0;
          payload_last_r  <= 1'b0;
          cnt             <= cnt - 8'd1;
          if (cnt == 8'd1) begin
            msg_done_r <= 1'b1;
            state      <= ST_CMD_RD;
          end else begin
            state <= ST_PAY_RD;
          end
        end
        default: state <= ST_CMD_RD;
      endcase
    end
  end

  assign bus.connect_o       = connect_r;
  assign bus.disconnect_o    = disconnect_r;
  assign bus.host_addr_o     = host_addr_r;
  assign bus.msg_start_o     = msg_start_r;
  assign bus.msg_length_o    = msg_length_r;
  assign bus.payload_o       = payload_r;
  assign bus.payload_valid_o = payload_valid_r;
  assign bus.payload_last_o  = payload_last_r;
  assign bus.msg_done_o      = msg_done_r;
  assign bus.err_o           = err_r;
endmodule

// File: tb/tb_interface_controller_out.sv
// tb/tb_interface_controller_out.sv - scoreboard bench for the read-side command decoder
module tb_interface_controller_out;
  import ifc_pkg::*;

  localparam int EV_CONN = 1, EV_DISC = 2, EV_ERR = 3, EV_START = 4, EV_BYTE = 5, EV_DONE = 6;

  typedef struct { int kind; int a; int b; } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  interface_controller_out_if #(.NUM_HOST(4)) bus();
  interface_controller_out #(.NUM_HOST(4), .HDR_OVERHEAD(21)) dut (.clk(clk), .rst(rst), .bus(bus));

  ev_t          exp_q[$];
  byte unsigned fifo_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  stall_en = 1'b0;
  int  hold_low_n = 0;
  int  cyc = 0;
  int  last_pop = -100;
  int  last_hs = -1;
  bit  prev_valid = 1'b0;
  logic [7:0] prev_data = 8'd0;

  task automatic chk(string nm, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic expect_ev(string nm, int kind, int a, int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected event actual_kind=%0d required=none (t=%0t)", nm, kind, $time);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, kind, e.kind);
      if (e.a >= 0) chk({nm, "_a"}, a, e.a);
      if (e.b >= 0) chk({nm, "_b"}, b, e.b);
    end
  endtask

  // Stimulus: high-level transactions turned into a byte stream plus expected host events.
  task automatic t_cmd(int op, int addr);
    int kind;
    kind = (op == 0) ? EV_CONN : (op == 1) ? EV_DISC : EV_ERR;
    exp_q.push_back('{kind, (kind == EV_ERR) ? -1 : addr, -1});
    fifo_q.push_back(8'((addr << 3) | op));
  endtask

  task automatic t_send(int addr, int n, int base);
    byte unsigned d;
    exp_q.push_back('{EV_START, addr, n});
    fifo_q.push_back(8'((addr << 3) | 2));
    fifo_q.push_back(8'(n + 21));
    for (int i = 0; i < n; i++) begin
      d = (base < 0) ? 8'($urandom_range(0, 255)) : 8'(base + i);
      fifo_q.push_back(d);
      exp_q.push_back('{EV_BYTE, int'(d), (i == n - 1) ? 1 : 0});
    end
    exp_q.push_back('{EV_DONE, -1, -1});
  endtask

  task automatic t_badlen(int addr, int len);
    exp_q.push_back('{EV_ERR, -1, -1});
    fifo_q.push_back(8'((addr << 3) | 2));
    fifo_q.push_back(8'(len));
  endtask

  task automatic wait_idle(string nm);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      chk({nm, "_timeout_pending"}, exp_q.size(), 0);
      fifo_q.delete();
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  function automatic int out_word();
    return int'({bus.readreq_o, bus.connect_o, bus.disconnect_o, bus.host_addr_o, bus.msg_start_o,
                 bus.msg_length_o, bus.payload_o, bus.payload_valid_o, bus.payload_last_o,
                 bus.msg_done_o, bus.err_o});
  endfunction

  // FIFO model: pops on readreq_o and presents the byte the following cycle.
  initial begin : drv
    bit pop_now;
    bus.empty_i = 1'b1;
    bus.data_i = 8'd0;
    bus.payload_ready_i = 1'b0;
    forever begin
      @(negedge clk);
      pop_now = bus.readreq_o;
      @(posedge clk);
      #2;
      if (pop_now) begin
        if (fifo_q.size() == 0) chk("pop_from_model_empty", 1, 0);
        else bus.data_i = fifo_q.pop_front();
      end
      bus.empty_i = (fifo_q.size() == 0) || (stall_en && $urandom_range(0, 2) == 0);
      if (hold_low_n > 0 && bus.payload_valid_o) begin
        bus.payload_ready_i = 1'b0;
        hold_low_n--;
      end else begin
        bus.payload_ready_i = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  always @(negedge clk) begin : mon
    int npulse;
    if (!rst) begin
      prev_valid = 1'b0;
      last_hs = -1;
    end else begin
      cyc++;
      npulse = int'(bus.connect_o) + int'(bus.disconnect_o) + int'(bus.err_o) + int'(bus.msg_start_o) + int'(bus.msg_done_o);
      if (npulse > 1 && !(npulse == 2 && bus.msg_start_o && bus.msg_done_o)) chk("multi_pulse", npulse, 1);
      if (bus.connect_o) begin
        expect_ev("connect", EV_CONN, int'(bus.host_addr_o), 0);
        chk("connect_latency", cyc - last_pop, 2);
      end
      if (bus.disconnect_o) begin
        expect_ev("disconnect", EV_DISC, int'(bus.host_addr_o), 0);
        chk("disconnect_latency", cyc - last_pop, 2);
      end
      if (bus.err_o) expect_ev("err", EV_ERR, 0, 0);
      if (bus.msg_start_o) begin
        expect_ev("msg_start", EV_START, int'(bus.host_addr_o), int'(bus.msg_length_o));
        last_hs = -1;
      end
      if (bus.payload_valid_o) begin
        if (prev_valid) chk("payload_stable", int'(bus.payload_o), int'(prev_data));
        if (bus.payload_ready_i) begin
          expect_ev("payload", EV_BYTE, int'(bus.payload_o), int'(bus.payload_last_o));
          if (!stall_en && hold_low_n == 0 && last_hs >= 0) chk("throughput_gap", cyc - last_hs, 3);
          last_hs = cyc;
          prev_valid = 1'b0;
        end else begin
          prev_valid = 1'b1;
          prev_data = bus.payload_o;
        end
      end else begin
        prev_valid = 1'b0;
      end
      if (bus.msg_done_o) expect_ev("msg_done", EV_DONE, 0, 0);
      if (bus.readreq_o) begin
        if (bus.empty_i) chk("pop_while_empty", 1, 0);
        last_pop = cyc;
      end
    end
  end

  initial begin : main
    int kind;
    #1;
    chk("reset_outputs", out_word(), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);

    t_cmd(0, 1);
    wait_idle("connect_addr1");
    t_cmd(1, 2);
    wait_idle("disconnect_addr2");
    t_send(3, 3, 8'hA1);
    wait_idle("send_a1_a3");
    t_send(0, 0, 0);
    t_cmd(7, 0);
    t_cmd(0, 4);
    wait_idle("zero_len_illegal");
    t_badlen(5, 20);
    t_cmd(1, 9);
    wait_idle("bad_length");
    t_send(15, 40, -1);
    wait_idle("long_message");

    stall_en = 1'b1;
    hold_low_n = 5;
    t_send(6, 5, -1);
    wait_idle("stall_hold");
    stall_en = 1'b0;
    hold_low_n = 0;

    t_send(5, 4, 8'h30);
    for (int n = 0; n < 200 && !bus.payload_valid_o; n++) @(posedge clk);
    chk("reset_test_reached_payload", int'(bus.payload_valid_o), 1);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("async_reset_outputs", out_word(), 0);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    t_cmd(0, 11);
    wait_idle("after_reset");

    for (int t = 0; t < 60; t++) begin
      stall_en = ($urandom_range(0, 1) == 1);
      kind = $urandom_range(0, 9);
      if (kind < 2) t_cmd(0, $urandom_range(0, 15));
      else if (kind < 4) t_cmd(1, $urandom_range(0, 15));
      else if (kind < 5) t_cmd($urandom_range(3, 7), $urandom_range(0, 15));
      else if (kind < 6) t_badlen($urandom_range(0, 15), $urandom_range(0, 20));
      else t_send($urandom_range(0, 15), $urandom_range(0, 6), -1);
      if (t % 6 == 5) wait_idle("random");
    end
    wait_idle("random_final");
    stall_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
